mac32_dot_issuer: RTL
=====================

Name: mac32_dot_issuer

Overview:
- Issue-side controller for the 2-stage FMA (Result = A + B*C). It streams (B,C) operand pairs into the FMA and feeds returned results back as the A operand, so a vector of products becomes one dot product.
- Hides the FMA latency by keeping MAC_LAT interleaved partial sums, then merges them with one final combine operation.
- Sits between an operand-stream producer and the FMA. It drives all FMA inputs and consumes Result and flags.

Parameters:
- MAC_LAT, 2, FMA issue-to-result latency in cycles; only 2 supported (elaboration assertion).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_fp_mode_i  in  2  00 FP32, 01 FP16, 10 mixed; latched at first accept of a vector
- cfg_rm_i  in  3  rounding mode; latched with cfg_fp_mode_i
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  operand pair accepted when valid&&ready
- in_b_i  in  32  B operand
- in_c_i  in  32  C operand
- in_last_i  in  1  final pair of vector
- mac_fp_mode_o  out  2  to FMA fp_mode
- mac_rm_o  out  3  to FMA Rounding_mode_i
- mac_a_o, mac_b_o, mac_c_o  out  32 each  to FMA A/B/C
- mac_result_i  in  32  FMA Result
- mac_nv_i, mac_of_i, mac_uf_i, mac_nx_i  in  1 each  FMA flags
- out_valid_o  out  1  dot result valid
- out_ready_i  in  1  consumer ready
- out_result_o  out  32  dot result (FP16 modes: low 16 bits, upper bits 0)
- out_flags_o  out  4  sticky {NV,OF,UF,NX}

Behaviour:
- Reset: state IDLE; in_ready_o=1; out_valid_o=0; out_result_o=0; out_flags_o=0; mac_*_o=0; partials=+0; tag pipe cleared; slot pointer=0.
- Tag pipe: MAC_LAT-deep shift register of {valid, slot, is_combine}. A result is consumed only in the cycle its tag reaches depth MAC_LAT; otherwise mac_result_i is ignored.
- FSM:
  - IDLE: on accept, latch cfg, clear sticky flags, enter ACCUM.
  - ACCUM: accept one pair per cycle; in_valid_i bubbles allowed. On accept of in_last_i, go to DRAIN.
  - DRAIN: in_ready_o=0; wait until the tag pipe holds no valid entry.
  - COMBINE: one issue cycle, then WAIT until the combine tag returns.
  - OUT: out_valid_o=1; hold out_result_o and out_flags_o until out_ready_i; then IDLE.
- Issue on accept:
  - mac_b_o=in_b_i, mac_c_o=in_c_i.
  - mac_a_o = mac_result_i if the returning tag targets the same slot (bypass), else partial[slot].
  - Slot pointer toggles only on accept.
- Writeback: a returning valid tag writes mac_result_i into partial[slot] and ORs the FMA flags into the sticky flags.
- COMBINE issue: A=partial0, B=partial1, C=1.0.
  - Mode 00 or 10: C=0x3F800000, mac_fp_mode_o=00 for this issue only.
  - Mode 01: C=0x00003C00, B=partial1[15:0].
- Outside the COMBINE issue cycle, mac_fp_mode_o and mac_rm_o equal the latched cfg.
- On a non-issue cycle mac_a_o, mac_b_o and mac_c_o are driven to 0.
- Latency: for N back-to-back pairs starting at cycle 0, out_valid_o rises at cycle N+5.
- Length-1 vector: partial1 stays +0, so the result is partial0 (+0 adds preserve value; -0+(+0)=+0 under RNE).
- Partials reset to +0 on entering IDLE.
- Reset mid-operation: everything returns to reset values. Stale FMA outputs are ignored because the tag pipe is cleared.
- cfg changes mid-vector are ignored.

Decomposition:
- Package mac_issue_pkg holds:
  - FP_MODE_FP32/FP16/MIXED encodings.
  - ONE_FP32=32'h3F800000 and ONE_FP16=16'h3C00.
  - State enum {IDLE, ACCUM, DRAIN, COMBINE, WAIT, OUT}.
  - Tag struct type.
- One sub-module, mac_issue_tagpipe: a MAC_LAT-deep tag shift register with an any-valid output.

Test Plan:
- FP32, N=2 back-to-back: (0x3F800000,0x40000000), (0x40400000,0x40800000) -> out_result_o=0x41600000 (14.0) at cycle 7, out_flags_o=0.
- FP16, same values (0x3C00·0x4000 + 0x4200·0x4400) -> out_result_o=0x00004B00; mac_fp_mode_o=01 on every issue, including combine.
- FP32, N=5 pairs of 1.0·1.0 with in_valid_i bubbles after pairs 2 and 3 -> 0x40A00000; bypass path exercised on back-to-back pairs.
- Backpressure: out_ready_i low for 3 cycles in OUT -> out_result_o and out_valid_o stable, in_ready_o=0; handshake returns FSM to IDLE, in_ready_o=1.
- Invalid: pair (0x7F800000, 0x00000000) -> out_result_o=0x7FC00000, out_flags_o[3]=NV=1; the next vector starts with flags cleared.
- Reset asserted in DRAIN -> all outputs at reset values next cycle; a fresh vector after release computes correctly.

Source files
------------

// File: rtl/mac_issue_pkg.sv
// mac_issue_pkg: shared types and constants for the dot-product issuer.
// FP mode codes, FMA unit constants, FSM states and the in-flight tag layout.
package mac_issue_pkg;

  localparam logic [1:0] FP_MODE_FP32  = 2'b00;
  localparam logic [1:0] FP_MODE_FP16  = 2'b01;
  localparam logic [1:0] FP_MODE_MIXED = 2'b10;

  localparam logic [31:0] ONE_FP32 = 32'h3F80_0000;
  localparam logic [15:0] ONE_FP16 = 16'h3C00;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    COMBINE,
    WAIT,
    OUT
  } state_e;

  typedef struct packed {
    logic valid;
    logic slot;
    logic is_combine;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/mac_issue_tagpipe.sv
// mac_issue_tagpipe: DEPTH-deep shift register tracking FMA ops in flight.
// Ports: tag_i (issued this cycle), ret_o (tag whose result returns now),
// any_valid_o (some op is still in flight after this cycle's return).
module mac_issue_tagpipe
  import mac_issue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] ret_o,
  output logic             any_valid_o
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_t'(tag_i);
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign ret_o = pipe_q[DEPTH-1];

  // The last stage retires this cycle, so it does not count as pending.
  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < DEPTH-1; i++) begin
      any_valid_o = any_valid_o | pipe_q[i].valid;
    end
  end

endmodule

// File: rtl/mac32_dot_issuer.sv
// mac32_dot_issuer: streams (B,C) pairs into a 2-stage FMA, keeps two
// interleaved partial sums, then merges them with one combine op.
// Ports: cfg_* (mode/rm, latched per vector), in_* (pair stream, valid/ready),
// mac_* (FMA operands out, result/flags in), out_* (dot result handshake).
module mac32_dot_issuer
  import mac_issue_pkg::*;
#(
  parameter int MAC_LAT = 2,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      cfg_fp_mode_i,
  input  logic [2:0]      cfg_rm_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_b_i,
  input  logic [XLEN-1:0] in_c_i,
  input  logic            in_last_i,
  output logic [1:0]      mac_fp_mode_o,
  output logic [2:0]      mac_rm_o,
  output logic [XLEN-1:0] mac_a_o,
  output logic [XLEN-1:0] mac_b_o,
  output logic [XLEN-1:0] mac_c_o,
  input  logic [XLEN-1:0] mac_result_i,
  input  logic            mac_nv_i,
  input  logic            mac_of_i,
  input  logic            mac_uf_i,
  input  logic            mac_nx_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_result_o,
  output logic [3:0]      out_flags_o
);

  if (MAC_LAT != 2) begin : g_lat_chk
    $error("mac32_dot_issuer: only MAC_LAT == 2 is supported");
  end

  state_e state_q, state_d;

  logic [1:0]      mode_q;
  logic [2:0]      rm_q;
  logic            slot_q;
  logic [XLEN-1:0] part0_q, part1_q;
  logic [3:0]      flags_q;
  logic [XLEN-1:0] res_q;

  logic             accept, cfg_ld, out_done;
  logic             wb_hit, cmb_hit, cmb_h, pend;
  logic [XLEN-1:0]  part_sel;
  logic [3:0]       flg;
  logic [TAG_W-1:0] ret_raw;
  tag_t             iss, ret;

  assign in_ready_o  = (state_q == IDLE) || (state_q == ACCUM);
  assign accept      = in_valid_i && in_ready_o;
  assign cfg_ld      = accept && (state_q == IDLE);
  assign out_valid_o = (state_q == OUT);
  assign out_done    = out_valid_o && out_ready_i;

  assign ret      = tag_t'(ret_raw);
  assign wb_hit   = ret.valid && !ret.is_combine;
  assign cmb_hit  = ret.valid && ret.is_combine;
  assign cmb_h    = (mode_q == FP_MODE_FP16);
  assign part_sel = slot_q ? part1_q : part0_q;
  assign flg      = {mac_nv_i, mac_of_i, mac_uf_i, mac_nx_i};

  mac_issue_tagpipe #(
    .DEPTH(MAC_LAT)
  ) u_tagpipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .tag_i      (iss),
    .ret_o      (ret_raw),
    .any_valid_o(pend)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = in_last_i ? DRAIN : ACCUM;
      ACCUM:   if (accept && in_last_i) state_d = DRAIN;
      DRAIN:   if (!pend) state_d = COMBINE;
      COMBINE: state_d = WAIT;
      WAIT:    if (cmb_hit) state_d = OUT;
      OUT:     if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first accept of a vector issues with the cfg being latched.
  always_comb begin
    iss           = '0;
    mac_a_o       = '0;
    mac_b_o       = '0;
    mac_c_o       = '0;
    mac_fp_mode_o = cfg_ld ? cfg_fp_mode_i : mode_q;
    mac_rm_o      = cfg_ld ? cfg_rm_i : rm_q;
    unique case (1'b1)
      accept: begin
        iss     = '{valid: 1'b1, slot: slot_q, is_combine: 1'b0};
        mac_b_o = in_b_i;
        mac_c_o = in_c_i;
        // Same-slot result lands this cycle: forward it as A.
        mac_a_o = (wb_hit && (ret.slot == slot_q)) ? mac_result_i
                                                   : part_sel;
      end
      (state_q == COMBINE): begin
        iss     = '{valid: 1'b1, slot: 1'b0, is_combine: 1'b1};
        mac_a_o = part0_q;
        if (cmb_h) begin
          mac_b_o = XLEN'(part1_q[15:0]);
          mac_c_o = XLEN'(ONE_FP16);
        end else begin
          mac_b_o       = part1_q;
          mac_c_o       = XLEN'(ONE_FP32);
          mac_fp_mode_o = FP_MODE_FP32;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      rm_q    <= '0;
      slot_q  <= 1'b0;
      part0_q <= '0;
      part1_q <= '0;
      flags_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_ld) begin
        mode_q <= cfg_fp_mode_i;
        rm_q   <= cfg_rm_i;
      end
      if (accept) slot_q <= ~slot_q;
      if (cfg_ld) flags_q <= '0;
      else if (ret.valid) flags_q <= flags_q | flg;
      if (wb_hit && !ret.slot) part0_q <= mac_result_i;
      if (wb_hit && ret.slot) part1_q <= mac_result_i;
      if (cmb_hit) begin
        res_q <= cmb_h ? XLEN'(mac_result_i[15:0]) : mac_result_i;
      end
      if (out_done) begin
        part0_q <= '0;
        part1_q <= '0;
        slot_q  <= 1'b0;
      end
    end
  end

  assign out_result_o = res_q;
  assign out_flags_o  = flags_q;

endmodule
